demux_deser: RTL and testbench

DEMUX_DESER -- requirements
Module: demux_deser

---
 rtl/demux_deser_pkg.sv | 34 +++
 rtl/demux_deser_slot_counter.sv | 41 ++++
 rtl/demux_deser.sv | 117 +++++++++++
 tb/tb_demux_deser.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/demux_deser_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : demux_deser_pkg
//  Purpose  : Shared types and constants for the 1-to-4 serial demux /
//             deserialiser: slot geometry, the "all slots written" mask
//             value and a slot-to-one-hot decode helper.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package demux_deser_pkg;

  localparam int unsigned SLOT_COUNT = 4;
  localparam int unsigned SLOT_W     = 2;
  localparam int unsigned WORD_W     = SLOT_COUNT;

  typedef logic [SLOT_W-1:0] slot_t;
  typedef logic [WORD_W-1:0] word_t;

  // Mux-side constants
  localparam slot_t SLOT_ZERO = '0;
  localparam slot_t SLOT_ONE  = slot_t'(1);
  localparam word_t MASK_NONE = '0;
  localparam word_t MASK_FULL = '1;

  // One-hot decode of a slot index into the shadow/mask bit it addresses.
  function automatic word_t slot_onehot(input slot_t s);
    word_t oh;
    oh = '0;
    oh[s] = 1'b1;
    return oh;
  endfunction

endpackage : demux_deser_pkg
`default_nettype wire

// File: rtl/demux_deser_slot_counter.sv
`default_nettype none
// ============================================================================
//  Module   : slot_counter
//  Purpose  : 2-bit wrap-around slot counter. A clear forces the count base
//             to slot 0; an enable in the same cycle then advances from that
//             base, so clear+enable lands on slot 1 (bit written to slot 0).
//  Ports    : clk   - rising-edge clock
//             rst   - asynchronous active-high reset (count -> 0)
//             clr   - restart the frame at slot 0
//             en    - a bit is consumed this cycle; advance one slot
//             count - current slot
//  Revision : 1.0  initial release
// ============================================================================
module slot_counter
  import demux_deser_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  clr,
  input  logic  en,
  output slot_t count
);

  slot_t base;
  slot_t count_next;

  always_comb begin
    base       = clr ? SLOT_ZERO : count;
    count_next = en ? slot_t'(base + SLOT_ONE) : base;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= SLOT_ZERO;
    end else begin
      count <= count_next;
    end
  end

endmodule : slot_counter
`default_nettype wire

// File: rtl/demux_deser.sv
`default_nettype none
// ============================================================================
//  Module   : demux_deser
//  Purpose  : Serial-to-parallel demultiplexer. Each qualified serial bit is
//             steered into one of four slots of a shadow register, chosen by
//             an internal counter (auto mode) or by {s_1,s_0} (manual mode).
//             When all four slots have been written the word is presented on
//             a_0..a_3 with a one-cycle word_valid pulse.
//  Ports    : clk, rst          - clock, asynchronous active-high reset
//             f, f_valid        - serial data bit and its qualifier
//             sync              - auto-mode frame start (bit goes to slot 0)
//             auto              - 1 = counter selects slot, 0 = {s_1,s_0}
//             s_0, s_1          - manual slot select
//             a_0..a_3          - registered parallel word (a_k = slot k)
//             word_valid        - pulse on each completed word
//             slot_0, slot_1    - internal slot counter
//  Revision : 1.0  initial release
// ============================================================================
module demux_deser
  import demux_deser_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic f,
  input  logic f_valid,
  input  logic sync,
  input  logic auto,
  input  logic s_0,
  input  logic s_1,
  output logic a_0,
  output logic a_1,
  output logic a_2,
  output logic a_3,
  output logic word_valid,
  output logic slot_0,
  output logic slot_1
);

  // State
  logic  auto_q;
  slot_t slot;
  word_t shadow;
  word_t mask;
  word_t word_q;
  logic  word_valid_q;

  // Next-state terms
  logic  auto_change;
  logic  frame_clr;
  logic  cnt_en;
  slot_t wr_slot;
  word_t wr_onehot;
  word_t mask_base;
  word_t mask_next;
  word_t shadow_next;
  logic  complete;

  always_comb begin
    // A mode change restarts framing before this cycle's bit is placed.
    auto_change = auto ^ auto_q;
    frame_clr   = auto_change | (auto & sync);
    cnt_en      = auto & f_valid;

    if (auto) begin
      wr_slot = frame_clr ? SLOT_ZERO : slot;
    end else begin
      wr_slot = {s_1, s_0};
    end
    wr_onehot = slot_onehot(wr_slot);

    mask_base   = frame_clr ? MASK_NONE : mask;
    mask_next   = mask_base;
    shadow_next = shadow;
    if (f_valid) begin
      mask_next   = mask_base | wr_onehot;
      shadow_next = (shadow & ~wr_onehot) | (f ? wr_onehot : MASK_NONE);
    end

    complete = f_valid && (mask_next == MASK_FULL);
  end

  slot_counter u_slot_counter (
    .clk   (clk),
    .rst   (rst),
    .clr   (frame_clr),
    .en    (cnt_en),
    .count (slot)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      auto_q       <= 1'b0;
      shadow       <= MASK_NONE;
      mask         <= MASK_NONE;
      word_q       <= MASK_NONE;
      word_valid_q <= 1'b0;
    end else begin
      auto_q       <= auto;
      shadow       <= shadow_next;
      mask         <= complete ? MASK_NONE : mask_next;
      word_valid_q <= complete;
      if (complete) begin
        word_q <= shadow_next;
      end
    end
  end

  assign a_0        = word_q[0];
  assign a_1        = word_q[1];
  assign a_2        = word_q[2];
  assign a_3        = word_q[3];
  assign word_valid = word_valid_q;
  assign slot_0     = slot[0];
  assign slot_1     = slot[1];

endmodule : demux_deser
`default_nettype wire

// File: tb/tb_demux_deser.sv
`default_nettype none
// ============================================================================
//  Module   : tb_demux_deser
//  Purpose  : Directed self-checking bench for demux_deser. Inputs change on
//             the falling edge; outputs are sampled 1 time unit after the
//             rising edge.
//  Revision : 1.0  initial release
// ============================================================================
module tb_demux_deser;

  logic clk = 1'b0;
  logic rst;
  logic f, f_valid, sync, auto, s_0, s_1;
  logic a_0, a_1, a_2, a_3, word_valid, slot_0, slot_1;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  demux_deser dut (
    .clk        (clk),
    .rst        (rst),
    .f          (f),
    .f_valid    (f_valid),
    .sync       (sync),
    .auto       (auto),
    .s_0        (s_0),
    .s_1        (s_1),
    .a_0        (a_0),
    .a_1        (a_1),
    .a_2        (a_2),
    .a_3        (a_3),
    .word_valid (word_valid),
    .slot_0     (slot_0),
    .slot_1     (slot_1)
  );

  wire [3:0] out  = {a_3, a_2, a_1, a_0};
  wire [1:0] slot = {slot_1, slot_0};

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 'h%0h, want 'h%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // One clock: apply inputs on the falling edge, sample after the rising edge.
  task automatic step(input logic fv, input logic fb, input logic sy,
                      input logic au, input logic [1:0] sl);
    @(negedge clk);
    f_valid = fv; f = fb; sync = sy; auto = au; {s_1, s_0} = sl;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; f = 0; f_valid = 0; sync = 0; auto = 0; s_0 = 0; s_1 = 0;
    #12;
    check("rst_out",  8'(out), 8'h0);
    check("rst_wv",   8'(word_valid), 8'h0);
    check("rst_slot", 8'(slot), 8'h0);
    @(negedge clk); rst = 1'b0;
    step(0, 0, 0, 1, 0);                 // settle into auto mode

    // Sync frame 1,0,1,1
    step(1, 1, 1, 1, 0);
    check("t1_wv1", 8'(word_valid), 8'h0);
    check("t1_slot1", 8'(slot), 8'h1);
    step(1, 0, 0, 1, 0);
    step(1, 1, 0, 1, 0);
    check("t1_wv3", 8'(word_valid), 8'h0);
    step(1, 1, 0, 1, 0);
    check("t1_out", 8'(out), 8'hD);
    check("t1_wv4", 8'(word_valid), 8'h1);
    check("t1_slot", 8'(slot), 8'h0);
    step(0, 0, 0, 1, 0);
    check("t1_wv_drop", 8'(word_valid), 8'h0);
    check("t1_hold", 8'(out), 8'hD);

    // Partial word discarded by sync carrying data
    step(1, 1, 0, 1, 0);
    step(1, 1, 0, 1, 0);
    step(1, 0, 1, 1, 0);
    step(1, 1, 0, 1, 0);
    step(1, 1, 0, 1, 0);
    check("t2_wv_early", 8'(word_valid), 8'h0);
    check("t2_hold", 8'(out), 8'hD);
    step(1, 1, 0, 1, 0);
    check("t2_out", 8'(out), 8'hE);
    check("t2_wv", 8'(word_valid), 8'h1);

    // Idle holds state; sync without data restarts the frame
    step(1, 1, 0, 1, 0);
    step(1, 1, 0, 1, 0);
    check("t7_slot2", 8'(slot), 8'h2);
    step(0, 1, 0, 1, 0);
    check("t7_idle_slot", 8'(slot), 8'h2);
    step(0, 1, 1, 1, 0);
    check("t7_sync_slot", 8'(slot), 8'h0);
    check("t7_sync_wv", 8'(word_valid), 8'h0);
    step(1, 0, 0, 1, 0);
    step(1, 1, 0, 1, 0);
    step(1, 0, 0, 1, 0);
    check("t7_wv_early", 8'(word_valid), 8'h0);
    step(1, 1, 0, 1, 0);
    check("t7_out", 8'(out), 8'hA);
    check("t7_wv", 8'(word_valid), 8'h1);

    // Continuous 8 bits: 1,0,0,0 then 0,1,1,1
    step(1, 1, 0, 1, 0);
    step(1, 0, 0, 1, 0);
    step(1, 0, 0, 1, 0);
    step(1, 0, 0, 1, 0);
    check("t4_out_a", 8'(out), 8'h1);
    check("t4_wv_a", 8'(word_valid), 8'h1);
    step(1, 0, 0, 1, 0);
    check("t4_wv_gap", 8'(word_valid), 8'h0);
    step(1, 1, 0, 1, 0);
    step(1, 1, 0, 1, 0);
    step(1, 1, 0, 1, 0);
    check("t4_out_b", 8'(out), 8'hE);
    check("t4_wv_b", 8'(word_valid), 8'h1);

    // Manual writes to slots 2,0,2,3,1 with 1,1,0,1,0 (sync ignored)
    step(1, 1, 0, 0, 2);
    step(1, 1, 1, 0, 0);
    step(1, 0, 0, 0, 2);
    step(1, 1, 0, 0, 3);
    check("t3_wv_early", 8'(word_valid), 8'h0);
    step(1, 0, 0, 0, 1);
    check("t3_out", 8'(out), 8'h9);
    check("t3_wv", 8'(word_valid), 8'h1);
    check("t3_slot", 8'(slot), 8'h0);

    // Auto -> manual toggle after two auto bits clears mask and slot
    step(1, 1, 0, 1, 0);
    step(1, 1, 0, 1, 0);
    check("t6_slot_pre", 8'(slot), 8'h2);
    step(1, 1, 0, 0, 2);
    check("t6_slot_clr", 8'(slot), 8'h0);
    step(1, 0, 0, 0, 3);
    check("t6_wv2", 8'(word_valid), 8'h0);
    step(1, 0, 0, 0, 0);
    check("t6_wv3", 8'(word_valid), 8'h0);
    step(1, 1, 0, 0, 1);
    check("t6_out", 8'(out), 8'h6);
    check("t6_wv4", 8'(word_valid), 8'h1);

    // Asynchronous reset mid-word
    step(1, 1, 0, 1, 0);
    step(1, 1, 0, 1, 0);
    step(1, 1, 0, 1, 0);
    check("t5_slot_pre", 8'(slot), 8'h3);
    #2;
    rst = 1'b1; f_valid = 1'b0;
    #1;
    check("t5_rst_out", 8'(out), 8'h0);
    check("t5_rst_wv", 8'(word_valid), 8'h0);
    check("t5_rst_slot", 8'(slot), 8'h0);
    @(negedge clk); rst = 1'b0;
    step(1, 0, 0, 1, 0);
    step(1, 1, 0, 1, 0);
    step(1, 0, 0, 1, 0);
    check("t5_wv_early", 8'(word_valid), 8'h0);
    step(1, 0, 0, 1, 0);
    check("t5_out", 8'(out), 8'h2);
    check("t5_wv", 8'(word_valid), 8'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_demux_deser
`default_nettype wire
